fir_mac_sequencer: RTL and testbench

Sequencer for the FIR filter's shared multiply-accumulate ALU (16×16 multiply plus 39-bit sum-in, registered result). For each accepted input sample it shifts an NTAPS-deep delay line and issues NTAPS MAC operations to the ALU, one per tap, chaining each result back as the next sum-in. It then presents the 39-bit filter output through a valid/ready handshake. The block sits between the sample stream source and the output sink and owns the coefficient bank.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 34 +++
 rtl/fir_mac_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: datapath widths, sequencer state encoding, sizing helper.
// No logic; compile before any FIR block that imports it.
// Used by the MAC sequencer, its coefficient bank, and the shared ALU.
package fir_pkg;

    // Sample and coefficient width.
    localparam int DW = 16;
    // Accumulator width: a 32-bit product plus headroom for up to 128 taps.
    localparam int AW = 39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Counter and address width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one write port and one combinational read port.
// Latency: a write is visible on the read port the cycle after the write edge.
// No backpressure. The caller filters writes and guarantees addresses are in range.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter  int NTAPS = 8,
    localparam int TW    = clog2_min1(NTAPS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we_i,
    input  logic [TW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic [TW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] coef_q [NTAPS];

    // Coefficient storage; cleared to zero by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else if (we_i) begin
            coef_q[addr_i] <= data_i;
        end
    end

    assign rd_data_o = coef_q[rd_addr_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: shifts the delay line and issues NTAPS chained MACs to the external ALU.
// Latency: out_valid rises NTAPS*(ALU_LAT+1) edges after the sample accept edge.
// Backpressure: in_ready only in IDLE; the result is held in OUT until out_ready.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter  int NTAPS   = 8,
    parameter  int ALU_LAT = 2,
    localparam int TW      = clog2_min1(NTAPS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    input  logic          coef_we,
    input  logic [TW-1:0] coef_addr,
    input  logic [DW-1:0] coef_data,
    output logic          coef_err,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_b,
    output logic [AW-1:0] alu_sum_in,
    input  logic [AW-1:0] alu_sum_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          busy
);

    localparam int WW = clog2_min1(ALU_LAT + 1);

    state_e        state_q;
    logic [TW-1:0] tap_q;
    logic [WW-1:0] wait_q;
    logic [AW-1:0] acc_q;
    logic [DW-1:0] x_q [NTAPS];
    logic [DW-1:0] alu_x_q;
    logic [DW-1:0] alu_b_q;
    logic [AW-1:0] alu_sum_in_q;
    logic          out_valid_q;
    logic          coef_err_q;

    logic          accept;
    logic          last_tap;
    logic          wait_done;
    logic [TW-1:0] rd_idx;
    logic [DW-1:0] coef_rd;
    logic          coef_ok;
    logic          coef_err_d;

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_tap   = (tap_q == TW'(NTAPS - 1));
    assign wait_done  = (wait_q == WW'(ALU_LAT));

    // Tap whose operands are loaded at the next issue edge: tap 0 on accept,
    // otherwise the following tap; held at 0 on the last tap to stay in range.
    assign rd_idx = (accept || last_tap) ? '0 : tap_q + 1'b1;

    // Writes land only in a quiet IDLE cycle; a sample offered in IDLE is always
    // accepted, so it takes priority. Out-of-range addresses are dropped as well.
    assign coef_ok    = coef_we && (state_q == IDLE) && !in_valid && (int'(coef_addr) < NTAPS);
    assign coef_err_d = coef_we && !coef_ok;

    fir_coef_bank #(
        .NTAPS (NTAPS)
    ) u_coef_bank (
        .clk       (clk),
        .rstn      (rstn),
        .we_i      (coef_ok),
        .addr_i    (coef_addr),
        .data_i    (coef_data),
        .rd_addr_i (rd_idx),
        .rd_data_o (coef_rd)
    );

    // Delay line: newest sample enters at x[0] on accept; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (accept) begin
            x_q[0] <= in_sample;
            for (int k = 1; k < NTAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    // Dropped-write flag, one cycle after the offending write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= coef_err_d;
        end
    end

    // Main sequencer: issue each tap, wait ALU_LAT+1 edges, chain the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            wait_q       <= '0;
            acc_q        <= '0;
            alu_x_q      <= '0;
            alu_b_q      <= '0;
            alu_sum_in_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // x[0] is being loaded this edge, so feed the sample directly.
                        state_q      <= MAC;
                        tap_q        <= '0;
                        wait_q       <= '0;
                        alu_x_q      <= in_sample;
                        alu_b_q      <= coef_rd;
                        alu_sum_in_q <= '0;
                    end
                end
                MAC: begin
                    if (wait_done) begin
                        acc_q  <= alu_sum_out;
                        wait_q <= '0;
                        if (last_tap) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            // acc is updated on this same edge, so chain the ALU result directly.
                            tap_q        <= tap_q + 1'b1;
                            alu_x_q      <= x_q[rd_idx];
                            alu_b_q      <= coef_rd;
                            alu_sum_in_q <= alu_sum_out;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_x      = alu_x_q;
    assign alu_b      = alu_b_q;
    assign alu_sum_in = alu_sum_in_q;
    assign out_valid  = out_valid_q;
    assign out_data   = acc_q;
    assign coef_err   = coef_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: default build (8 taps, ALU latency 2) plus a 4-tap, latency-3 build.
// Each build drives a behavioural pipelined MAC ALU; results are compared against a dot-product model.
// Stimulus mixes directed cases with randomized samples, coefficients and backpressure.
module tb_fir_mac_sequencer;

    localparam int NT  = 8;
    localparam int L   = 2;
    localparam int NTB = 4;
    localparam int LB  = 3;

    logic        clk = 1'b0;
    logic        rstn;

    logic        in_valid, in_ready, coef_we, coef_err, out_valid, out_ready, busy;
    logic [15:0] in_sample, coef_data, alu_x, alu_b;
    logic [2:0]  coef_addr;
    logic [38:0] alu_sum_in, alu_sum_out, out_data;

    logic        b_in_valid, b_in_ready, b_coef_we, b_coef_err, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_in_sample, b_coef_data, b_alu_x, b_alu_b;
    logic [1:0]  b_coef_addr;
    logic [38:0] b_alu_sum_in, b_alu_sum_out, b_out_data;

    int checks = 0;
    int errors = 0;

    // Reference state: delay line and coefficient bank as plain arrays.
    logic [15:0] mx [NT];
    logic [15:0] mc [NT];

    always #5 clk = ~clk;

    fir_mac_sequencer #(.NTAPS(NT), .ALU_LAT(L)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .alu_x(alu_x), .alu_b(alu_b), .alu_sum_in(alu_sum_in), .alu_sum_out(alu_sum_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    fir_mac_sequencer #(.NTAPS(NTB), .ALU_LAT(LB)) u_dut_b (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sample(b_in_sample),
        .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data), .coef_err(b_coef_err),
        .alu_x(b_alu_x), .alu_b(b_alu_b), .alu_sum_in(b_alu_sum_in), .alu_sum_out(b_alu_sum_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    // Behavioural ALUs: x*b + sum_in, visible L edges after the inputs change.
    logic [38:0] pipe_a [L];
    logic [38:0] pipe_b [LB];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < L; i++) pipe_a[i] <= '0;
        end else begin
            pipe_a[0] <= {23'b0, alu_x} * {23'b0, alu_b} + alu_sum_in;
            for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign alu_sum_out = pipe_a[L-1];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LB; i++) pipe_b[i] <= '0;
        end else begin
            pipe_b[0] <= {23'b0, b_alu_x} * {23'b0, b_alu_b} + b_alu_sum_in;
            for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign b_alu_sum_out = pipe_b[LB-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_y();
        logic [63:0] s = 64'd0;
        for (int k = 0; k < NT; k++) s += 64'(mc[k]) * 64'(mx[k]);
        return s & ((64'd1 << 39) - 1);
    endfunction

    task automatic model_push(input logic [15:0] s);
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = s;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NT; k++) begin
            mx[k] = '0;
            mc[k] = '0;
        end
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        mc[a] = d;
        chk("wr_err_quiet", {63'b0, coef_err}, 64'd0);
    endtask

    // One full sample on the default build; optional output stall, illegal write
    // in MAC, and write colliding with the accept edge.
    task automatic run_sample(input logic [15:0] s, input int hold, input bit inj_mac,
                              input bit inj_acc, output logic [38:0] y);
        int          cnt;
        bit          saw_ready;
        logic [63:0] exp;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) chk("idle_timeout", 64'd0, 64'd1);
        in_valid = 1'b1; in_sample = s;
        if (inj_acc) begin
            coef_we = 1'b1; coef_addr = 3'd5; coef_data = 16'hBEEF;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0; in_sample = 16'($urandom);
        model_push(s);
        exp = model_y();
        if (inj_acc) chk("accept_we_err", {63'b0, coef_err}, 64'd1);
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
        cnt = 0;
        saw_ready = 1'b0;
        while (!out_valid && cnt < 1000) begin
            if (in_ready) saw_ready = 1'b1;
            if (inj_mac && cnt == 5) begin
                coef_we = 1'b1; coef_addr = 3'd3; coef_data = 16'd99;
            end
            @(posedge clk); #1;
            cnt++;
            if (inj_mac && cnt == 6) begin
                coef_we = 1'b0;
                chk("mac_we_err", {63'b0, coef_err}, 64'd1);
            end
            if (inj_mac && cnt == 7) chk("mac_we_err_clr", {63'b0, coef_err}, 64'd0);
        end
        chk("latency", 64'(cnt), 64'(NT * (L + 1)));
        chk("ready_low_in_mac", {63'b0, saw_ready}, 64'd0);
        chk("y", 64'(out_data), exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_sample = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_data", 64'(out_data), exp);
            chk("hold_vld", {63'b0, out_valid}, 64'd1);
            chk("hold_rdy", {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        y = out_data;
        chk("hs_vld_low", {63'b0, out_valid}, 64'd0);
        chk("hs_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [38:0] y;
        int          cnt;
        bit          seen;

        rstn = 1'b0;
        in_valid = 1'b0; in_sample = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_sample = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
        b_out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_coef_err", {63'b0, coef_err}, 64'd0);
        chk("rst_alu", {alu_x, alu_b, 32'b0} | 64'(alu_sum_in), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Impulse response.
        for (int k = 0; k < NT; k++) wr_coef(k, 16'(k + 1));
        for (int i = 0; i < NT; i++) begin
            run_sample((i == 0) ? 16'd1 : 16'd0, 0, 1'b0, 1'b0, y);
            chk("impulse", 64'(y), 64'(i + 1));
        end

        // Output stall for 10 cycles.
        run_sample(16'($urandom), 10, 1'b0, 1'b0, y);

        // Full-scale constant input.
        for (int k = 0; k < NT; k++) wr_coef(k, 16'hFFFF);
        for (int i = 0; i < 9; i++) begin
            run_sample(16'hFFFF, 0, 1'b0, 1'b0, y);
            if (i >= 7) chk("const_full", 64'(y), 64'd34358689800);
        end

        // Dropped writes: during MAC and colliding with an accept.
        for (int k = 0; k < NT; k++) wr_coef(k, 16'(k + 1));
        run_sample(16'd7, 0, 1'b1, 1'b0, y);
        run_sample(16'd9, 0, 1'b0, 1'b1, y);
        run_sample(16'd0, 0, 1'b0, 1'b0, y);

        // Reset in the middle of tap 4.
        @(negedge clk);
        in_valid = 1'b1; in_sample = 16'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4 * (L + 1)) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_vld", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_alu", {alu_x, alu_b, 32'b0} | 64'(alu_sum_in), 64'd0);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_vld_after_rst", {63'b0, seen}, 64'd0);
        for (int k = 0; k < NT; k++) wr_coef(k, 16'(k + 1));
        run_sample(16'd1, 0, 1'b0, 1'b0, y);
        chk("impulse_after_rst", 64'(y), 64'd1);

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                wr_coef(int'($urandom_range(0, NT - 1)), 16'($urandom));
            run_sample(16'($urandom), int'($urandom_range(0, 3)),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, y);
        end

        // Second build: 4 taps, ALU latency 3.
        for (int k = 0; k < NTB; k++) begin
            @(negedge clk);
            b_coef_we = 1'b1; b_coef_addr = 2'(k); b_coef_data = 16'(k + 2);
            @(posedge clk); #1;
            b_coef_we = 1'b0;
        end
        @(negedge clk);
        b_in_valid = 1'b1; b_in_sample = 16'd10;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        cnt = 0;
        while (!b_out_valid && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("b_latency", 64'(cnt), 64'(NTB * (LB + 1)));
        chk("b_y", 64'(b_out_data), 64'd20);
        @(posedge clk); #1;
        chk("b_hs_vld_low", {63'b0, b_out_valid}, 64'd0);
        chk("b_hs_ready", {63'b0, b_in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
